// File: rtl/move_sequencer.sv
// -----------------------------------------------------------------------------
// move_sequencer
//
// Game-flow controller for a Connect-4 board. It consumes one-cycle move
// pulses from the input debouncer, keeps the cursor column, per-column fill
// heights and the player to move, issues each piece write to the board store,
// waits for the win checker's verdict, and either hands the turn over or ends
// the game on a win or a draw.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   new_game        one-cycle pulse, restarts the game from any state
//   left_pulse      move cursor one column left (wraps 0 -> COLS-1)
//   right_pulse     move cursor one column right (wraps COLS-1 -> 0)
//   put_pulse       drop a piece into the cursor column
//   wr_valid/ready  piece write handshake towards the board store
//   wr_row/col      target cell of the piece (row 0 = bottom)
//   wr_player       owner of the piece (0 = P1, 1 = P2)
//   check_done      one-cycle verdict strobe from the win checker
//   check_win       qualifies check_done: the last piece completed four
//   cursor_col      current cursor column
//   cur_player      player to move
//   invalid_move    one-cycle pulse: put on a full column
//   game_over       level, game has ended
//   winner          00 none, 01 P1, 10 P2, 11 draw
//   move_count      pieces placed so far
//   dbg_state       current FSM state (PLAY=0, WRITE=1, CHECK=2, OVER=3)
//
// Write handshake: wr_valid rises one cycle after an accepted put and, with
// wr_row/wr_col/wr_player, is held stable until the cycle where wr_valid and
// wr_ready are both high; that cycle is the transfer. wr_valid drops on the
// following cycle. Only new_game or rst may withdraw a pending request.
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module move_sequencer #(
  parameter int COLS = 7,
  parameter int ROWS = 6,
  parameter int CW   = $clog2(COLS),
  parameter int RW   = $clog2(ROWS + 1),
  parameter int MW   = $clog2(ROWS * COLS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          new_game,
  input  logic          left_pulse,
  input  logic          right_pulse,
  input  logic          put_pulse,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [RW-1:0] wr_row,
  output logic [CW-1:0] wr_col,
  output logic          wr_player,
  input  logic          check_done,
  input  logic          check_win,
  output logic [CW-1:0] cursor_col,
  output logic          cur_player,
  output logic          invalid_move,
  output logic          game_over,
  output logic [1:0]    winner,
  output logic [MW-1:0] move_count,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    WRITE = 2'd1,
    CHECK = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [CW-1:0] CENTER    = CW'(COLS / 2);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [RW-1:0] FULL      = RW'(ROWS);
  localparam logic [MW-1:0] MAX_MOVES = MW'(ROWS * COLS);

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  state_t        state, state_n;
  logic [RW-1:0] heights   [COLS];
  logic [RW-1:0] heights_n [COLS];
  logic [CW-1:0] cursor_n;
  logic          player_n;
  logic [MW-1:0] count_n;
  logic          wr_valid_n;
  logic [RW-1:0] wr_row_n;
  logic [CW-1:0] wr_col_n;
  logic          wr_player_n;
  logic          invalid_n;
  logic          over_n;
  logic [1:0]    winner_n;

  assign dbg_state = state;

  // Next-state and next-output logic. Everything holds by default; the
  // invalid_move pulse is the only output that self-clears.
  always_comb begin
    state_n     = state;
    heights_n   = heights;
    cursor_n    = cursor_col;
    player_n    = cur_player;
    count_n     = move_count;
    wr_valid_n  = wr_valid;
    wr_row_n    = wr_row;
    wr_col_n    = wr_col;
    wr_player_n = wr_player;
    invalid_n   = 1'b0;
    over_n      = game_over;
    winner_n    = winner;

    if (new_game) begin
      // Restart wins over anything in flight, including a pending write.
      state_n     = PLAY;
      for (int i = 0; i < COLS; i++) heights_n[i] = '0;
      cursor_n    = CENTER;
      player_n    = 1'b0;
      count_n     = '0;
      wr_valid_n  = 1'b0;
      wr_row_n    = '0;
      wr_col_n    = '0;
      wr_player_n = 1'b0;
      over_n      = 1'b0;
      winner_n    = WIN_NONE;
    end else begin
      case (state)
        PLAY: begin
          // One pulse per cycle, left > right > put; the rest are dropped.
          if (left_pulse) begin
            cursor_n = (cursor_col == '0) ? LAST_COL : cursor_col - CW'(1);
          end else if (right_pulse) begin
            cursor_n = (cursor_col == LAST_COL) ? '0 : cursor_col + CW'(1);
          end else if (put_pulse) begin
            if (heights[cursor_col] == FULL) begin
              invalid_n = 1'b1;
            end else begin
              wr_valid_n  = 1'b1;
              wr_row_n    = heights[cursor_col];
              wr_col_n    = cursor_col;
              wr_player_n = cur_player;
              state_n     = WRITE;
            end
          end
        end

        WRITE: begin
          if (wr_valid && wr_ready) begin
            heights_n[wr_col] = heights[wr_col] + RW'(1);
            count_n           = move_count + MW'(1);
            wr_valid_n        = 1'b0;
            state_n           = CHECK;
          end
        end

        CHECK: begin
          if (check_done) begin
            if (check_win) begin
              over_n   = 1'b1;
              winner_n = wr_player ? WIN_P2 : WIN_P1;
              state_n  = OVER;
            end else if (move_count == MAX_MOVES) begin
              over_n   = 1'b1;
              winner_n = WIN_DRAW;
              state_n  = OVER;
            end else begin
              player_n = ~cur_player;
              state_n  = PLAY;
            end
          end
        end

        OVER: begin
          // Frozen until new_game or rst.
        end

        default: state_n = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PLAY;
      for (int i = 0; i < COLS; i++) heights[i] <= '0;
      cursor_col   <= CENTER;
      cur_player   <= 1'b0;
      move_count   <= '0;
      wr_valid     <= 1'b0;
      wr_row       <= '0;
      wr_col       <= '0;
      wr_player    <= 1'b0;
      invalid_move <= 1'b0;
      game_over    <= 1'b0;
      winner       <= WIN_NONE;
    end else begin
      state        <= state_n;
      heights      <= heights_n;
      cursor_col   <= cursor_n;
      cur_player   <= player_n;
      move_count   <= count_n;
      wr_valid     <= wr_valid_n;
      wr_row       <= wr_row_n;
      wr_col       <= wr_col_n;
      wr_player    <= wr_player_n;
      invalid_move <= invalid_n;
      game_over    <= over_n;
      winner       <= winner_n;
    end
  end

endmodule
